// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MOV/MOC memory handshake controller:
// FSM state encoding, access size codes, default timeout and load helpers.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CLEAR,
        RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    // Right-aligns the RAM read bus to the access size and applies sign
    // extension when size[2] is set. Idempotent if the RAM already did it.
    function automatic logic [31:0] format_load(input logic [31:0] raw,
                                                input logic [2:0]  size);
        logic [31:0] res;
        case (size[1:0])
            SZ_BYTE: res = size[2] ? {{24{raw[7]}}, raw[7:0]}  : {24'h0, raw[7:0]};
            SZ_HALF: res = size[2] ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // True when a halfword/word address is not naturally aligned.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        logic res;
        case (size)
            SZ_HALF: res = addr_lo[0];
            SZ_WORD: res = (addr_lo != 2'b00);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// 8-bit watchdog counter for the DRIVE/CLEAR handshake phases.
// Counting stops once the limit is reached so expired stays high until cleared.
module mem_timeout_ctr
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] count;

    assign expired = (count == LIMIT);

    // Cycle counter: clear wins over enable, saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + 8'd1;
    end

endmodule

// File: rtl/mem_handshake_ctrl.sv
// Bridges single load/store requests onto the RAM's MOV/MOC handshake.
// All outputs are registered. MOV rises one cycle after the address/data bus
// is latched so the RAM always sees a settled bus under the strobe.
// Build option: define MEMCTL_ALIGN_CHECK_EN to reject misaligned halfword and
// word accesses with an error response instead of passing them to the RAM.
module mem_handshake_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [2:0]  ReqSize,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqData,
    output logic        RspValid,
    output logic [31:0] RspData,
    output logic        RspErr,
    output logic        MOV,
    output logic        ReadWrite,
    output logic [2:0]  MS_2_0,
    output logic [31:0] Address,
    output logic [31:0] DataIn,
    output logic        MOCoff,
    input  logic        MOC,
    input  logic [31:0] DataOut
);

    state_t      state, state_next;
    logic        accept;
    logic        bad_req;
    logic        expired;
    logic        ctr_clear;
    logic        ctr_enable;
    logic        err_q, err_next;
    logic [31:0] rd_q, rd_next;

    assign accept     = ReqValid && ReqReady;
    assign ctr_enable = (state == DRIVE) || (state == CLEAR);

`ifdef MEMCTL_ALIGN_CHECK_EN
    assign bad_req = (ReqSize[1:0] == 2'b11) || misaligned(ReqSize[1:0], ReqAddr[1:0]);
`else
    assign bad_req = (ReqSize[1:0] == 2'b11);
`endif

    mem_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (Clk),
        .rst    (Reset),
        .clear  (ctr_clear),
        .enable (ctr_enable),
        .expired(expired)
    );

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state plus next error flag / response data.
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        err_next   = err_q;
        rd_next    = rd_q;
        ctr_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    ctr_clear  = 1'b1;
                    err_next   = bad_req;
                    rd_next    = '0;
                    state_next = bad_req ? RESP : DRIVE;
                end
            end
            DRIVE: begin
                // A completion on the same edge as expiry still counts as success.
                if (MOC) begin
                    rd_next    = ReadWrite ? format_load(DataOut, MS_2_0) : '0;
                    ctr_clear  = 1'b1;
                    state_next = CLEAR;
                end else if (expired) begin
                    err_next   = 1'b1;
                    ctr_clear  = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (!MOC) begin
                    state_next = RESP;
                end else if (expired) begin
                    err_next   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch and transfer bookkeeping.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            err_q     <= 1'b0;
            rd_q      <= '0;
            ReadWrite <= 1'b1;
            MS_2_0    <= '0;
            Address   <= '0;
            DataIn    <= '0;
        end else begin
            err_q <= err_next;
            rd_q  <= rd_next;
            if (accept) begin
                ReadWrite <= ~ReqWrite;
                MS_2_0    <= ReqSize;
                Address   <= ReqAddr;
                DataIn    <= ReqData;
            end
        end
    end

    // Registered handshake and response outputs derived from the next state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ReqReady <= 1'b0;
            MOV      <= 1'b0;
            MOCoff   <= 1'b1;
            RspValid <= 1'b0;
            RspErr   <= 1'b0;
            RspData  <= '0;
        end else begin
            ReqReady <= (state_next == IDLE);
            MOV      <= (state == DRIVE) && (state_next == DRIVE);
            MOCoff   <= (state_next == CLEAR);
            RspValid <= (state_next == RESP);
            RspErr   <= (state_next == RESP) && err_next;
            RspData  <= ((state_next == RESP) && !err_next) ? rd_next : '0;
        end
    end

endmodule
